// File: rtl/ni_req_packetizer.sv
// Request-side NI packetizer: one write request becomes a head flit, body flits and a tail flit.
// Optional tail checksum is enabled with `define NI_TAIL_CHECKSUM_EN.

package ni_pkg;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned CHUNK_WIDTH = 14;

    function automatic int unsigned calc_num_flits(input int unsigned width);
        return (width + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    endfunction

    typedef struct packed {
        logic [2:0] number_of_flits;
        logic [1:0] flag_bits;
        logic [2:0] mode_bits;
        logic [3:0] destination_addr;
        logic [3:0] source_addr;
    } head_flit_s;

    typedef struct packed {
        logic [14:0] data_bits;
        logic        flit_identifier;
    } body_flit_s;

    typedef struct packed {
        logic [14:0] data_bits;
        logic        flit_identifier;
    } tail_flit_s;
endpackage

module ni_req_packetizer #(
    parameter int unsigned DATA_WIDTH = ni_pkg::DATA_WIDTH,
    parameter logic [3:0]  NODE_ADDR  = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [3:0]            req_dest,
    input  logic [2:0]            req_mode,
    input  logic [1:0]            req_flags,
    output logic [15:0]           flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  busy
);
    localparam int unsigned NUM_BODY_FLITS = ni_pkg::calc_num_flits(DATA_WIDTH);
    localparam int unsigned PAD_W          = NUM_BODY_FLITS * ni_pkg::CHUNK_WIDTH;
    localparam int unsigned CNT_W          = (NUM_BODY_FLITS > 1) ? $clog2(NUM_BODY_FLITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_BODY_FLITS - 1);

    if (NUM_BODY_FLITS + 2 > 7) begin : g_flit_count_check
        $error("ni_req_packetizer: NUM_BODY_FLITS+2 does not fit number_of_flits");
    end

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [PAD_W-1:0] data_q;
    logic [3:0]       dest_q;
    logic [2:0]       mode_q;
    logic [1:0]       flags_q;
    logic [14:0]      tail_bits;
    logic [13:0]      chunk [NUM_BODY_FLITS];
    logic             accept;
    logic             xfer;

    ni_pkg::head_flit_s head_flit;
    ni_pkg::body_flit_s body_flit;
    ni_pkg::tail_flit_s tail_flit;

    assign accept    = req_valid && (state == IDLE);
    assign xfer      = flit_valid && flit_ready;
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_comb begin
        for (int unsigned i = 0; i < NUM_BODY_FLITS; i++) begin
            chunk[i] = data_q[i*ni_pkg::CHUNK_WIDTH +: ni_pkg::CHUNK_WIDTH];
        end
    end

`ifdef NI_TAIL_CHECKSUM_EN
    logic [PAD_W-1:0] req_pad;
    logic [14:0]      csum_in, csum_q;

    // Checksum is folded from the live request so it is ready alongside the captured payload.
    always_comb begin
        req_pad = PAD_W'(req_data);
        csum_in = '0;
        for (int unsigned i = 0; i < NUM_BODY_FLITS; i++) begin
            csum_in = csum_in ^ {1'b0, req_pad[i*ni_pkg::CHUNK_WIDTH +: ni_pkg::CHUNK_WIDTH]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_in;
        end
    end

    assign tail_bits = csum_q;
`else
    assign tail_bits = '0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        flit_out   = '0;

        head_flit.number_of_flits  = 3'(NUM_BODY_FLITS + 2);
        head_flit.flag_bits        = flags_q;
        head_flit.mode_bits        = mode_q;
        head_flit.destination_addr = dest_q;
        head_flit.source_addr      = NODE_ADDR;

        body_flit.data_bits        = {1'b0, chunk[cnt]};
        body_flit.flit_identifier  = 1'b0;

        tail_flit.data_bits        = tail_bits;
        tail_flit.flit_identifier  = 1'b1;

        case (state)
            IDLE: begin
                if (req_valid) state_next = HEAD;
            end
            HEAD: begin
                flit_out = head_flit;
                if (xfer) begin
                    state_next = BODY;
                    cnt_next   = '0;
                end
            end
            BODY: begin
                flit_out = body_flit;
                if (xfer) begin
                    if (cnt == LAST_CNT) state_next = TAIL;
                    else                 cnt_next   = cnt + 1'b1;
                end
            end
            TAIL: begin
                flit_out = tail_flit;
                if (xfer) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flit_valid <= 1'b0;
            data_q     <= '0;
            dest_q     <= '0;
            mode_q     <= '0;
            flags_q    <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            flit_valid <= (state_next != IDLE);
            if (accept) begin
                data_q  <= PAD_W'(req_data);
                dest_q  <= req_dest;
                mode_q  <= req_mode;
                flags_q <= req_flags;
            end
        end
    end
endmodule

// File: tb/tb_ni_req_packetizer.sv
// Directed self-checking bench for ni_req_packetizer (NODE_ADDR=1, 32-bit payload, 5-flit packets).

module tb_ni_req_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = '0;
    logic [3:0]  req_dest = '0;
    logic [2:0]  req_mode = '0;
    logic [1:0]  req_flags = '0;
    logic [15:0] flit_out;
    logic        flit_valid;
    logic        flit_ready = 1'b1;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] xlog [0:255];
    int          xcount = 0;

`ifdef NI_TAIL_CHECKSUM_EN
    localparam logic [15:0] TAIL_ONE  = 16'h0003;
    localparam logic [15:0] TAIL_ONES = 16'h001F;
`else
    localparam logic [15:0] TAIL_ONE  = 16'h0001;
    localparam logic [15:0] TAIL_ONES = 16'h0001;
`endif

    ni_req_packetizer #(.DATA_WIDTH(32), .NODE_ADDR(4'h1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_dest   (req_dest),
        .req_mode   (req_mode),
        .req_flags  (req_flags),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flit_valid && flit_ready) begin
            xlog[xcount[7:0]] <= flit_out;
            xcount <= xcount + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [31:0] d, input logic [3:0] dest);
        req_data  = d;
        req_dest  = dest;
        req_mode  = 3'b010;
        req_flags = 2'b01;
        req_valid = 1'b1;
    endtask

    // Called right after the accepting edge with flit_ready high; ends one cycle after the tail transfer.
    task automatic expect_packet(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] exp [5];
        exp = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++) begin
            check({tag, "_valid"}, {15'd0, flit_valid}, 16'd1);
            check({tag, "_flit"}, flit_out, exp[i]);
            check({tag, "_ready"}, {15'd0, req_ready}, 16'd0);
            step();
        end
        check({tag, "_end_valid"}, {15'd0, flit_valid}, 16'd0);
        check({tag, "_end_busy"}, {15'd0, busy}, 16'd0);
        check({tag, "_end_ready"}, {15'd0, req_ready}, 16'd1);
    endtask

    initial begin
        int base;

        // reset
        #2 rst = 1'b1;
        #1;
        check("rst_valid", {15'd0, flit_valid}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_flit", flit_out, 16'h0000);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_ready", {15'd0, req_ready}, 16'd1);

        // single packet, data = 1
        set_req(32'h0000_0001, 4'h3);
        step();
        req_valid = 1'b0;
        expect_packet("pkt_one", 16'hAA31, 16'h0002, 16'h0000, 16'h0000, TAIL_ONE);

        // all-ones payload exercises padding of the last chunk
        set_req(32'hFFFF_FFFF, 4'h3);
        step();
        req_valid = 1'b0;
        expect_packet("pkt_ones", 16'hAA31, 16'h7FFE, 16'h7FFE, 16'h001E, TAIL_ONES);

        // backpressure on head and second body
        set_req(32'h0000_0001, 4'h3);
        step();
        req_valid = 1'b0;
        base = xcount;
        flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_head_valid", {15'd0, flit_valid}, 16'd1);
            check("bp_head_flit", flit_out, 16'hAA31);
            step();
        end
        flit_ready = 1'b1;
        step();
        check("bp_body0", flit_out, 16'h0002);
        step();
        flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_body1_valid", {15'd0, flit_valid}, 16'd1);
            check("bp_body1_flit", flit_out, 16'h0000);
            step();
        end
        flit_ready = 1'b1;
        step();
        check("bp_body2", flit_out, 16'h0000);
        step();
        check("bp_tail", flit_out, TAIL_ONE);
        step();
        check("bp_end_valid", {15'd0, flit_valid}, 16'd0);
        check("bp_count", 16'(xcount - base), 16'd5);
        check("bp_log0", xlog[base], 16'hAA31);
        check("bp_log1", xlog[base+1], 16'h0002);
        check("bp_log2", xlog[base+2], 16'h0000);
        check("bp_log3", xlog[base+3], 16'h0000);
        check("bp_log4", xlog[base+4], TAIL_ONE);

        // req_valid held high, payload changed mid-packet
        set_req(32'h0000_0001, 4'h3);
        step();
        req_data = 32'hFFFF_FFFF;
        expect_packet("b2b_a", 16'hAA31, 16'h0002, 16'h0000, 16'h0000, TAIL_ONE);
        step();
        req_data = 32'h0000_0001;
        expect_packet("b2b_b", 16'hAA31, 16'h7FFE, 16'h7FFE, 16'h001E, TAIL_ONES);
        req_valid = 1'b0;
        step();
        check("b2b_idle_valid", {15'd0, flit_valid}, 16'd0);

        // reset during BODY cnt=1
        set_req(32'hFFFF_FFFF, 4'h3);
        step();
        req_valid = 1'b0;
        step();
        step();
        check("mid_body1", flit_out, 16'h7FFE);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {15'd0, flit_valid}, 16'd0);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {15'd0, req_ready}, 16'd1);
        set_req(32'h0000_0001, 4'h3);
        step();
        req_valid = 1'b0;
        expect_packet("post_rst", 16'hAA31, 16'h0002, 16'h0000, 16'h0000, TAIL_ONE);

        // request arriving while busy waits for IDLE
        set_req(32'hFFFF_FFFF, 4'h3);
        step();
        set_req(32'h0000_0001, 4'h5);
        expect_packet("busy_first", 16'hAA31, 16'h7FFE, 16'h7FFE, 16'h001E, TAIL_ONES);
        step();
        req_valid = 1'b0;
        expect_packet("busy_second", 16'hAA51, 16'h0002, 16'h0000, 16'h0000, TAIL_ONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
